// File: rtl/ifetch_queue.sv
// rtl/ifetch_queue.sv - instruction fetch with PC-tagged circular queue, redirect flush and end-of-program stop
// Optional zero-latency queue bypass when IFQ_BYPASS_EN is defined.
module ifetch_queue #(
    parameter int          DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_inst,
    output logic        dec_valid,
    output logic [31:0] dec_inst,
    output logic [31:0] dec_pc,
    input  logic        dec_ready,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic        halted
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL = CNT_W'(DEPTH);

    logic [31:0]      pc_q, pc_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             stop_q, stop_d;
    logic [31:0]      inst_mem_q [DEPTH];
    logic [31:0]      inst_mem_d [DEPTH];
    logic [31:0]      pc_mem_q [DEPTH];
    logic [31:0]      pc_mem_d [DEPTH];

    logic q_valid, q_pop, space, fetch_ok, word_ok, push, sentinel;
    logic bypass, byp_take;
    logic unused_pc_bits;

    assign unused_pc_bits = ^redirect_pc[1:0];

    assign q_valid  = (count_q != '0);
    assign q_pop    = q_valid & dec_ready;
    assign space    = (count_q != FULL) | q_pop;
    assign fetch_ok = !stop_q & !redirect & space;
    assign word_ok  = (imem_inst != 32'h0);
    assign sentinel = fetch_ok & !word_ok;

`ifdef IFQ_BYPASS_EN
    // An empty queue hands the ROM word straight to the decoder; the sentinel never takes this path.
    assign bypass = (count_q == '0) & !stop_q & !redirect & word_ok;
`else
    assign bypass = 1'b0;
`endif
    assign byp_take = bypass & dec_ready;
    assign push     = fetch_ok & word_ok & !byp_take;

    always_comb begin
        pc_d       = pc_q;
        rd_ptr_d   = rd_ptr_q;
        wr_ptr_d   = wr_ptr_q;
        count_d    = count_q;
        stop_d     = stop_q;
        inst_mem_d = inst_mem_q;
        pc_mem_d   = pc_mem_q;
        if (redirect) begin
            pc_d     = {redirect_pc[31:2], 2'b00};
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
            stop_d   = 1'b0;
        end else begin
            if (push) begin
                inst_mem_d[wr_ptr_q] = imem_inst;
                pc_mem_d[wr_ptr_q]   = pc_q;
                wr_ptr_d             = wr_ptr_q + 1'b1;
            end
            if (push | byp_take) begin
                pc_d = pc_q + 32'd4;
            end
            if (sentinel) begin
                stop_d = 1'b1;
            end
            if (q_pop) begin
                rd_ptr_d = rd_ptr_q + 1'b1;
            end
            count_d = count_q + CNT_W'(push) - CNT_W'(q_pop);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc_q     <= RESET_PC;
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
            stop_q   <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                inst_mem_q[i] <= 32'h0;
                pc_mem_q[i]   <= 32'h0;
            end
        end else begin
            pc_q       <= pc_d;
            rd_ptr_q   <= rd_ptr_d;
            wr_ptr_q   <= wr_ptr_d;
            count_q    <= count_d;
            stop_q     <= stop_d;
            inst_mem_q <= inst_mem_d;
            pc_mem_q   <= pc_mem_d;
        end
    end

    always_comb begin
        dec_valid = q_valid;
        dec_inst  = q_valid ? inst_mem_q[rd_ptr_q] : 32'h0;
        dec_pc    = q_valid ? pc_mem_q[rd_ptr_q] : 32'h0;
        if (bypass) begin
            dec_valid = 1'b1;
            dec_inst  = imem_inst;
            dec_pc    = pc_q;
        end
    end

    assign imem_addr = pc_q;
    assign halted    = stop_q & (count_q == '0);

endmodule

// File: tb/tb_ifetch_queue.sv
// tb/tb_ifetch_queue.sv - randomized bench for ifetch_queue against a queue-based reference model
module tb_ifetch_queue;

    localparam int          DEPTH    = 4;
    localparam logic [31:0] RESET_PC = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [31:0] imem_addr;
    logic [31:0] imem_inst;
    logic        dec_valid;
    logic [31:0] dec_inst;
    logic [31:0] dec_pc;
    logic        dec_ready = 1'b1;
    logic        redirect = 1'b0;
    logic [31:0] redirect_pc = 32'h0;
    logic        halted;

    ifetch_queue #(.DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
        .clk        (clk),
        .rst        (rst),
        .imem_addr  (imem_addr),
        .imem_inst  (imem_inst),
        .dec_valid  (dec_valid),
        .dec_inst   (dec_inst),
        .dec_pc     (dec_pc),
        .dec_ready  (dec_ready),
        .redirect   (redirect),
        .redirect_pc(redirect_pc),
        .halted     (halted)
    );

    always #5 clk = ~clk;

    logic [31:0] rom [256];
    assign imem_inst = rom[imem_addr[9:2]];

    function automatic logic [31:0] rom_at(input logic [31:0] a);
        return rom[a[9:2]];
    endfunction

    int tests = 0;
    int fails = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: a plain queue of {pc, inst}, the fetch PC and the stop flag.
    logic [63:0] mq [$];
    logic [31:0] mpc = RESET_PC;
    bit          mstop = 1'b0;
    logic [31:0] w;
    bit          ev, pop, space;

    always @(negedge clk) begin
        if (rst) begin
            mq.delete();
            mpc   = RESET_PC;
            mstop = 1'b0;
        end
        ev = (mq.size() != 0);
        check("m_dec_valid", 32'(dec_valid), 32'(ev));
        check("m_dec_inst", dec_inst, ev ? mq[0][31:0] : 32'h0);
        check("m_dec_pc", dec_pc, ev ? mq[0][63:32] : 32'h0);
        check("m_halted", 32'(halted), 32'(mstop && !ev));
        check("m_imem_addr", imem_addr, mpc);
        if (!rst) begin
            w     = rom_at(mpc);
            pop   = ev && dec_ready;
            space = (mq.size() < DEPTH) || pop;
            if (redirect) begin
                mq.delete();
                mpc   = {redirect_pc[31:2], 2'b00};
                mstop = 1'b0;
            end else begin
                if (pop) void'(mq.pop_front());
                if (!mstop && space) begin
                    if (w != 32'h0) begin
                        mq.push_back({mpc, w});
                        mpc = mpc + 32'd4;
                    end else begin
                        mstop = 1'b1;
                    end
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    int unsigned rdy_p;
    logic [31:0] last_pc;

    initial begin
        for (int i = 0; i < 256; i++) rom[i] = $urandom | 32'h1;
        rom[0]  = 32'hFFC10113;
        rom[1]  = 32'h00112223;
        rom[51] = 32'h0;

        #1 rst = 1'b1;
        #1;
        check("rst_dec_valid", 32'(dec_valid), 32'h0);
        check("rst_dec_inst", dec_inst, 32'h0);
        check("rst_dec_pc", dec_pc, 32'h0);
        check("rst_halted", 32'(halted), 32'h0);
        check("rst_imem_addr", imem_addr, RESET_PC);
        repeat (2) step();
        rst = 1'b0;
        check("lat_before_edge", 32'(dec_valid), 32'h0);
        step();
        check("lat_valid", 32'(dec_valid), 32'h1);
        check("seq_pc0", dec_pc, 32'h0);
        check("seq_inst0", dec_inst, 32'hFFC10113);
        step();
        check("seq_pc1", dec_pc, 32'h4);
        check("seq_inst1", dec_inst, 32'h00112223);
        step();
        check("seq_pc2", dec_pc, 32'h8);

        // Stall until full, then release into a simultaneous push/pop.
        rst = 1'b1;
        dec_ready = 1'b0;
        step();
        rst = 1'b0;
        repeat (10) step();
        check("stall_valid", 32'(dec_valid), 32'h1);
        check("stall_head_pc", dec_pc, 32'h0);
        check("stall_head_inst", dec_inst, 32'hFFC10113);
        check("stall_addr", imem_addr, 32'h10);
        dec_ready = 1'b1;
        step();
        check("full_pushpop_pc", dec_pc, 32'h4);
        check("full_pushpop_addr", imem_addr, 32'h14);
        step();
        check("drain_pc", dec_pc, 32'h8);

        // Run into the sentinel at 0xCC.
        redirect = 1'b1;
        redirect_pc = 32'hB0;
        step();
        redirect = 1'b0;
        check("redir_flush", 32'(dec_valid), 32'h0);
        check("redir_addr", imem_addr, 32'hB0);
        last_pc = 32'hFFFF_FFFF;
        for (int k = 0; k < 30 && !halted; k++) begin
            step();
            if (dec_valid) last_pc = dec_pc;
        end
        check("sent_last_pc", last_pc, 32'hC8);
        check("sent_addr", imem_addr, 32'hCC);
        check("sent_halted", 32'(halted), 32'h1);
        repeat (2) step();
        check("sent_hold_valid", 32'(dec_valid), 32'h0);
        check("sent_hold_addr", imem_addr, 32'hCC);

        // Asynchronous reset from the halted state, between edges.
        #1 rst = 1'b1;
        #1;
        check("arst_halted", 32'(halted), 32'h0);
        check("arst_addr", imem_addr, RESET_PC);
        step();
        rst = 1'b0;
        step();
        check("arst_resume_valid", 32'(dec_valid), 32'h1);
        check("arst_resume_pc", dec_pc, RESET_PC);

        // Asynchronous reset mid-stream with a non-empty queue.
        #1 rst = 1'b1;
        #1;
        check("arst_mid_valid", 32'(dec_valid), 32'h0);
        check("arst_mid_addr", imem_addr, RESET_PC);
        step();
        rst = 1'b0;

        // Halt again, then redirect out of it and flush three queued entries.
        redirect = 1'b1;
        redirect_pc = 32'hC8;
        step();
        redirect = 1'b0;
        repeat (3) step();
        check("rehalt", 32'(halted), 32'h1);
        dec_ready = 1'b0;
        redirect = 1'b1;
        redirect_pc = 32'h10;
        step();
        redirect = 1'b0;
        check("redir_unhalt", 32'(halted), 32'h0);
        repeat (3) step();
        check("three_head", dec_pc, 32'h10);
        check("three_addr", imem_addr, 32'h1C);
        redirect = 1'b1;
        redirect_pc = 32'h8B;
        step();
        redirect = 1'b0;
        check("redir3_valid", 32'(dec_valid), 32'h0);
        check("redir3_addr", imem_addr, 32'h88);
        check("redir3_halted", 32'(halted), 32'h0);
        dec_ready = 1'b1;
        step();
        check("redir3_next_pc", dec_pc, 32'h88);

        // Randomized traffic with occasional sentinels, wrap-around redirects and async resets.
        for (int i = 0; i < 256; i++) rom[i] = ($urandom_range(0, 24) == 0) ? 32'h0 : ($urandom | 32'h1);
        rom[0] = 32'h13;
        rdy_p = 0;
        for (int c = 0; c < 3000; c++) begin
            step();
            if (c % 50 == 0) rdy_p = $urandom_range(0, 3);
            dec_ready   = ($urandom_range(0, 3) >= rdy_p);
            redirect    = ($urandom_range(0, 29) == 0);
            redirect_pc = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(0, 15)))
                                                      : 32'($urandom_range(0, 1023));
            if ($urandom_range(0, 399) == 0) begin
                #1 rst = 1'b1;
                #1;
                check("rnd_arst_valid", 32'(dec_valid), 32'h0);
                step();
                rst = 1'b0;
            end
        end
        redirect = 1'b0;
        step();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
